// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N systolic array of MAC cells.
// Clears the array, streams k_len operand columns/rows with a diagonal skew,
// flushes the pipeline, then steps a row-select through the results.
// Optional feature: define SYS_CTRL_PERF_EN to enable the perf_cycles job counter
// (otherwise perf_cycles is tied to zero).
module systolic_ctrl #(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned K_W    = 8,
   parameter int unsigned PE_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [K_W-1:0]          k_len,
   output logic                    busy,
   output logic                    done,
   output logic                    rd_en,
   output logic [K_W-1:0]          rd_addr,
   input  logic [N*DATA_W-1:0]     a_col_in,
   input  logic [N*DATA_W-1:0]     b_row_in,
   output logic                    pe_rst_n,
   output logic [N*DATA_W-1:0]     arr_a,
   output logic [N*DATA_W-1:0]     arr_b,
   output logic                    c_valid,
   output logic [$clog2(N)-1:0]    c_row,
   output logic [31:0]             perf_cycles
);

   localparam int unsigned ROW_W = $clog2(N);
   localparam int unsigned F     = N * (PE_LAT + 1) + 1;
   localparam int unsigned FL_W  = $clog2(F + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [K_W-1:0]    k_len_q, k_len_d;
   logic [K_W-1:0]    rd_addr_q, rd_addr_d;
   logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [ROW_W-1:0]  c_row_q, c_row_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_en_q, rd_en_d;
   logic              pe_rst_n_q, pe_rst_n_d;
   logic              c_valid_q, c_valid_d;
   logic              vld_q;

   // Next-state and registered-output decode; outputs follow the next state.
   always_comb begin
      state_d     = state_q;
      k_len_d     = k_len_q;
      rd_addr_d   = rd_addr_q;
      flush_cnt_d = flush_cnt_q;
      c_row_d     = c_row_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      rd_en_d     = 1'b0;
      pe_rst_n_d  = 1'b1;
      c_valid_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  k_len_d = k_len;
                  state_d = S_CLEAR;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_CLEAR: begin
            rd_addr_d = '0;
            state_d   = S_FEED;
         end
         S_FEED: begin
            if (rd_addr_q == K_W'(k_len_q - K_W'(1))) begin
               rd_addr_d   = '0;
               flush_cnt_d = '0;
               state_d     = S_FLUSH;
            end else begin
               rd_addr_d = K_W'(rd_addr_q + K_W'(1));
            end
         end
         S_FLUSH: begin
            if (flush_cnt_q == FL_W'(F - 1)) begin
               c_row_d = '0;
               state_d = S_DRAIN;
            end else begin
               flush_cnt_d = FL_W'(flush_cnt_q + FL_W'(1));
            end
         end
         S_DRAIN: begin
            if (c_row_q == ROW_W'(N - 1)) begin
               state_d = S_DONE;
            end else begin
               c_row_d = ROW_W'(c_row_q + ROW_W'(1));
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      rd_en_d    = (state_d == S_FEED);
      pe_rst_n_d = (state_d != S_CLEAR);
      c_valid_d  = (state_d == S_DRAIN);
   end

   // FSM state, counters and control outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         k_len_q     <= '0;
         rd_addr_q   <= '0;
         flush_cnt_q <= '0;
         c_row_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         pe_rst_n_q  <= 1'b0;
         c_valid_q   <= 1'b0;
         vld_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         rd_addr_q   <= rd_addr_d;
         flush_cnt_q <= flush_cnt_d;
         c_row_q     <= c_row_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_en_q     <= rd_en_d;
         pe_rst_n_q  <= pe_rst_n_d;
         c_valid_q   <= c_valid_d;
         vld_q       <= rd_en_q;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rd_en    = rd_en_q;
   assign rd_addr  = rd_addr_q;
   assign pe_rst_n = pe_rst_n_q;
   assign c_valid  = c_valid_q;
   assign c_row    = c_row_q;

   // Per-lane skew: lane i is i+1 registers deep; invalid slots enter as +0.0.
   for (genvar i = 0; i < int'(N); i++) begin : g_lane
      localparam int unsigned D = i + 1;

      logic [DATA_W-1:0] a_pipe_q [D];
      logic [DATA_W-1:0] a_pipe_d [D];
      logic [DATA_W-1:0] b_pipe_q [D];
      logic [DATA_W-1:0] b_pipe_d [D];

      // Shift the lane forward; the entry stage is zeroed when no operand is valid.
      always_comb begin
         a_pipe_d[0] = vld_q ? a_col_in[i*DATA_W +: DATA_W] : '0;
         b_pipe_d[0] = vld_q ? b_row_in[i*DATA_W +: DATA_W] : '0;
         for (int unsigned s = 1; s < D; s++) begin
            a_pipe_d[s] = a_pipe_q[s-1];
            b_pipe_d[s] = b_pipe_q[s-1];
         end
      end

      // Lane delay registers.
      always_ff @(posedge clk) begin
         if (!rst) begin
            for (int unsigned s = 0; s < D; s++) begin
               a_pipe_q[s] <= '0;
               b_pipe_q[s] <= '0;
            end
         end else begin
            for (int unsigned s = 0; s < D; s++) begin
               a_pipe_q[s] <= a_pipe_d[s];
               b_pipe_q[s] <= b_pipe_d[s];
            end
         end
      end

      assign arr_a[i*DATA_W +: DATA_W] = a_pipe_q[D-1];
      assign arr_b[i*DATA_W +: DATA_W] = b_pipe_q[D-1];
   end

`ifdef SYS_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   // Job cycle counter: clear on accepted start, count busy cycles, saturate.
   always_comb begin
      perf_d = perf_q;
      if (state_q == S_IDLE && start) begin
         perf_d = '0;
      end else if (busy_q && (perf_q != '1)) begin
         perf_d = 32'(perf_q + 32'd1);
      end
   end

   // Perf counter register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = 32'd0;
`endif

endmodule
